// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: one memory read per PC value, valid/ready to decode, pc_write back to the PC.
// Optional WAIT timeout with sticky fetch_err is enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_resp #(
    parameter logic [31:2] RESET_ADDR = 30'h0c00,
    parameter int          MAX_WAIT   = 15,
    parameter int          CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] pc,
    input  logic        flush,
    input  logic        id_ready,
    output logic        mem_req,
    output logic [31:2] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:2] instr_pc,
    output logic        instr_valid,
    output logic        pc_write,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, VALID} state_t;

    state_t state, state_nx;
    logic   discard;
    logic   ack;
    logic   timeout;

    // An ack only counts against a request we actually have outstanding.
    assign ack = mem_ack & mem_req;

`ifdef IFETCH_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == WAIT) && !ack && (wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == WAIT && !ack && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timeout)
                fetch_err <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = ISSUE;
            ISSUE: if (!flush) state_nx = WAIT;
            WAIT: begin
                if (ack)
                    state_nx = (discard || flush) ? ISSUE : VALID;
                else if (timeout)
                    state_nx = ISSUE;
            end
            VALID: if (flush || id_ready) state_nx = ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    assign pc_write = !rst && (flush || (state == VALID && id_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_ADDR;
            instr       <= '0;
            instr_pc    <= RESET_ADDR;
            instr_valid <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ISSUE: begin
                    // On flush the PC is loaded at this edge; latch the target next cycle.
                    if (!flush) begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                        if (!(discard || flush)) begin
                            instr       <= mem_rdata;
                            instr_pc    <= mem_addr;
                            instr_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        discard <= 1'b0;
                    end else if (flush) begin
                        // The bus has no cancel, so remember to drop the stale data.
                        discard <= 1'b1;
                    end
                end
                VALID: if (flush || id_ready) instr_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed bench for ifetch_resp with a small PC-register model driven by pc_write.
module tb_ifetch_resp;

    logic        clk, rst;
    logic [31:2] pc, tgt;
    logic        flush, id_ready;
    logic        mem_req;
    logic [31:2] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:2] instr_pc;
    logic        instr_valid, pc_write, fetch_err;

    int total = 0;
    int passed = 0;
    int pw_cnt = 0;
    int pw_ref;
    bit seen_bad = 0;

    ifetch_resp dut (
        .clk(clk), .rst(rst), .pc(pc), .flush(flush), .id_ready(id_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .pc_write(pc_write), .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: sequential advance on accept, branch target on flush.
    always @(posedge clk or posedge rst) begin
        if (rst)           pc <= 30'h0c00;
        else if (pc_write) pc <= flush ? tgt : pc + 30'd1;
    end

    always @(posedge clk) begin
        if (pc_write) pw_cnt++;
        if (instr_valid && instr == 32'hDEAD_BEEF) seen_bad = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b1; id_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0; tgt = '0;
        cyc(); cyc();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0c00);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'h0c00);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_pc_write_forced", 32'(pc_write), 32'd0);
        flush = 1'b0;
        rst = 1'b0;

        // Basic fetch with 1-cycle ack and immediate accept
        cyc();
        chk("idle_no_req", 32'(mem_req), 32'd0);
        cyc();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'h0c00);
        pw_ref = pw_cnt;
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005; id_ready = 1'b1;
        cyc();
        mem_ack = 1'b0;
        #1;
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_instr_pc", 32'(instr_pc), 32'h0c00);
        chk("t1_pc_write", 32'(pc_write), 32'd1);
        cyc();
        chk("t1_valid_drop", 32'(instr_valid), 32'd0);
        chk("t1_pc_write_low", 32'(pc_write), 32'd0);
        chk("t1_one_pulse", 32'(pw_cnt - pw_ref), 32'd1);

        // Decode stalls for 5 cycles
        id_ready = 1'b0;
        cyc();
        chk("t2_addr", 32'(mem_addr), 32'h0c01);
        mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
        cyc();
        mem_ack = 1'b0;
        pw_ref = pw_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            chk("t2_hold_instr", instr, 32'h0000_1111);
            chk("t2_hold_pc", 32'(instr_pc), 32'h0c01);
            chk("t2_hold_pw", 32'(pc_write), 32'd0);
            cyc();
        end
        chk("t2_no_pulses", 32'(pw_cnt - pw_ref), 32'd0);
        id_ready = 1'b1;
        #1;
        chk("t2_accept_pw", 32'(pc_write), 32'd1);
        cyc();
        id_ready = 1'b0;
        chk("t2_single_pulse", 32'(pw_cnt - pw_ref), 32'd1);
        chk("t2_valid_drop", 32'(instr_valid), 32'd0);

        // Flush during WAIT; late ack data must be dropped
        cyc();
        chk("t3_addr", 32'(mem_addr), 32'h0c02);
        pw_ref = pw_cnt;
        flush = 1'b1; tgt = 30'h0c10;
        #1;
        chk("t3_flush_pw", 32'(pc_write), 32'd1);
        cyc();
        flush = 1'b0;
        cyc(); cyc();
        chk("t3_req_held", 32'(mem_req), 32'd1);
        chk("t3_addr_stable", 32'(mem_addr), 32'h0c02);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        cyc();
        mem_ack = 1'b0;
        chk("t3_req_drop", 32'(mem_req), 32'd0);
        chk("t3_no_valid", 32'(instr_valid), 32'd0);
        chk("t3_one_pulse", 32'(pw_cnt - pw_ref), 32'd1);
        cyc();
        chk("t3_new_addr", 32'(mem_addr), 32'h0c10);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        cyc();
        mem_ack = 1'b0;
        chk("t3_instr", instr, 32'hAAAA_0001);
        chk("t3_instr_pc", 32'(instr_pc), 32'h0c10);
        chk("t3_never_deadbeef", 32'(seen_bad), 32'd0);

        // Flush together with id_ready in VALID
        pw_ref = pw_cnt;
        id_ready = 1'b1; flush = 1'b1; tgt = 30'h0c20;
        #1;
        chk("t4_pw", 32'(pc_write), 32'd1);
        cyc();
        flush = 1'b0; id_ready = 1'b0;
        chk("t4_valid_drop", 32'(instr_valid), 32'd0);
        chk("t4_one_pulse", 32'(pw_cnt - pw_ref), 32'd1);
        cyc();
        chk("t4_addr", 32'(mem_addr), 32'h0c20);

        // Flush on the same cycle as ack
        flush = 1'b1; tgt = 30'h0c30; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001;
        cyc();
        flush = 1'b0; mem_ack = 1'b0;
        chk("t4b_no_valid", 32'(instr_valid), 32'd0);
        chk("t4b_instr_kept", instr, 32'hAAAA_0001);
        chk("t4b_req_drop", 32'(mem_req), 32'd0);
        cyc();
        chk("t4b_addr", 32'(mem_addr), 32'h0c30);

        // Reset asserted while a request is outstanding
        rst = 1'b1;
        #1;
        chk("t5_req", 32'(mem_req), 32'd0);
        chk("t5_addr", 32'(mem_addr), 32'h0c00);
        chk("t5_instr", instr, 32'd0);
        chk("t5_instr_pc", 32'(instr_pc), 32'h0c00);
        chk("t5_valid", 32'(instr_valid), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        cyc(); cyc();
        chk("t5_no_capture", instr, 32'd0);
        chk("t5_valid_low", 32'(instr_valid), 32'd0);
        mem_ack = 1'b0;
        rst = 1'b0;
        cyc(); cyc();
        chk("t5_resume_addr", 32'(mem_addr), 32'h0c00);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; id_ready = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("t5_resume_instr", instr, 32'h1234_5678);
        chk("t5_resume_valid", 32'(instr_valid), 32'd1);
        cyc();
        id_ready = 1'b0;

        // Ack while no request is outstanding is ignored
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        cyc();
        mem_ack = 1'b0;
        cyc();
        chk("t6_no_valid", 32'(instr_valid), 32'd0);
        chk("t6_instr_kept", instr, 32'h1234_5678);
        chk("t6_req", 32'(mem_req), 32'd1);
        chk("t6_addr", 32'(mem_addr), 32'h0c01);

`ifdef IFETCH_TIMEOUT_EN
        repeat (13) cyc();
        chk("t7_pre_req", 32'(mem_req), 32'd1);
        chk("t7_pre_err", 32'(fetch_err), 32'd0);
        cyc();
        chk("t7_err", 32'(fetch_err), 32'd1);
        chk("t7_req_drop", 32'(mem_req), 32'd0);
        cyc();
        chk("t7_reissue", 32'(mem_req), 32'd1);
        chk("t7_same_addr", 32'(mem_addr), 32'h0c01);
        mem_ack = 1'b1; mem_rdata = 32'h600D_0001; id_ready = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("t7_instr", instr, 32'h600D_0001);
        chk("t7_err_sticky", 32'(fetch_err), 32'd1);
`else
        repeat (20) cyc();
        chk("t7_req_held", 32'(mem_req), 32'd1);
        chk("t7_no_err", 32'(fetch_err), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h600D_0001; id_ready = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("t7_instr", instr, 32'h600D_0001);
        chk("t7_err_low", 32'(fetch_err), 32'd0);
`endif
        id_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
